// File: rtl/fir_sequencer.sv
// FIR MAC sequencer: drives an external DSP accumulator tap by tap and scales its result.
// Define FIR_SAT_EN to saturate the scaled output; otherwise the output wraps to 16 bits.
module fir_sequencer #(
  parameter int unsigned NTAPS   = 10,
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned SHIFT   = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sample_valid_i,
  input  logic        coef_we_i,
  input  logic [3:0]  coef_addr_i,
  input  logic [15:0] coef_data_i,
  input  logic [32:0] result_i,
  output logic        mac_clr_o,
  output logic        mac_en_o,
  output logic [7:0]  tapnum_o,
  output logic [15:0] tap_o,
  output logic        busy_o,
  output logic [15:0] y_o,
  output logic        y_valid_o,
  output logic        overrun_o,
  output logic        coef_rej_o
);

  localparam int unsigned TAP_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NCOEF  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  state_t             state;
  logic [15:0]        coef [NCOEF];
  logic [TAP_W-1:0]   tap_idx;
  logic [CNT_W-1:0]   drain_cnt;
  logic               accept_c;
  logic signed [32:0] s_c;
  logic [15:0]        y_next_c;

  // New work and coefficient writes are only taken while no sequence is in flight.
  assign accept_c = (state == IDLE) || (state == OUTPUT);

  assign s_c = $signed(result_i) >>> SHIFT;

`ifdef FIR_SAT_EN
  always_comb begin
    y_next_c = s_c[15:0];
    if (s_c > 33'sd32767)
      y_next_c = 16'h7FFF;
    else if (s_c < -33'sd32768)
      y_next_c = 16'h8000;
  end
`else
  logic unused_c;
  assign unused_c = ^s_c[32:16];
  assign y_next_c = s_c[15:0];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      tap_idx    <= '0;
      drain_cnt  <= '0;
      mac_clr_o  <= 1'b0;
      mac_en_o   <= 1'b0;
      tapnum_o   <= '0;
      tap_o      <= '0;
      busy_o     <= 1'b0;
      y_o        <= '0;
      y_valid_o  <= 1'b0;
      overrun_o  <= 1'b0;
      coef_rej_o <= 1'b0;
      for (int i = 0; i < int'(NCOEF); i++) coef[i] <= '0;
    end else begin
      mac_clr_o  <= 1'b0;
      mac_en_o   <= 1'b0;
      tapnum_o   <= '0;
      tap_o      <= '0;
      y_valid_o  <= 1'b0;
      overrun_o  <= sample_valid_i && !accept_c;
      coef_rej_o <= 1'b0;

      if (coef_we_i) begin
        if (accept_c && (32'(coef_addr_i) < NTAPS))
          coef[coef_addr_i] <= coef_data_i;
        else
          coef_rej_o <= 1'b1;
      end

      case (state)
        IDLE, OUTPUT: begin
          if (sample_valid_i) begin
            state     <= CLEAR;
            mac_clr_o <= 1'b1;
            busy_o    <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        CLEAR: begin
          state    <= RUN;
          tap_idx  <= '0;
          mac_en_o <= 1'b1;
          tap_o    <= coef[0];
          busy_o   <= 1'b1;
        end
        RUN: begin
          if (tap_idx == TAP_W'(NTAPS - 1)) begin
            // A zero-latency DSP has its result ready immediately after the last MAC.
            if (MAC_LAT == 0) begin
              state     <= OUTPUT;
              y_o       <= y_next_c;
              y_valid_o <= 1'b1;
              busy_o    <= 1'b0;
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
              busy_o    <= 1'b1;
            end
          end else begin
            tap_idx  <= tap_idx + TAP_W'(1);
            mac_en_o <= 1'b1;
            tapnum_o <= CNT_W'(tap_idx + TAP_W'(1));
            tap_o    <= coef[tap_idx + TAP_W'(1)];
            busy_o   <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == CNT_W'(MAC_LAT - 1)) begin
            state     <= OUTPUT;
            y_o       <= y_next_c;
            y_valid_o <= 1'b1;
            busy_o    <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
            busy_o    <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer with a behavioural DSP accumulator model.
// Honours FIR_SAT_EN for the expected output reduction.
module tb_fir_sequencer;

  localparam int unsigned NTAPS   = 10;
  localparam int unsigned MAC_LAT = 2;
  localparam int unsigned SHIFT   = 0;
  localparam int          LAT     = NTAPS + MAC_LAT + 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        sample_valid_i;
  logic        coef_we_i;
  logic [3:0]  coef_addr_i;
  logic [15:0] coef_data_i;
  logic [32:0] result_i;
  logic        mac_clr_o;
  logic        mac_en_o;
  logic [7:0]  tapnum_o;
  logic [15:0] tap_o;
  logic        busy_o;
  logic [15:0] y_o;
  logic        y_valid_o;
  logic        overrun_o;
  logic        coef_rej_o;

  fir_sequencer #(.NTAPS(NTAPS), .MAC_LAT(MAC_LAT), .SHIFT(SHIFT)) dut (
    .clk_i(clk), .rst_i(rst_i), .sample_valid_i(sample_valid_i),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
    .result_i(result_i), .mac_clr_o(mac_clr_o), .mac_en_o(mac_en_o),
    .tapnum_o(tapnum_o), .tap_o(tap_o), .busy_o(busy_o), .y_o(y_o),
    .y_valid_o(y_valid_o), .overrun_o(overrun_o), .coef_rej_o(coef_rej_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] y;
    int          cyc;
  } exp_t;

  exp_t               sb[$];
  int                 checks = 0;
  int                 failures = 0;
  int                 cyc = 0;
  int                 yv_cnt = 0;
  int                 ovr_cnt = 0;
  bit                 mon_en = 1'b0;
  logic [15:0]        coef_m [16];
  logic signed [15:0] x_win [16];
  logic signed [32:0] acc, res_q;
  logic               ovr_en = 1'b0;
  logic [32:0]        ovr_val = '0;
  logic [15:0]        last_y = '0;
  logic [15:0]        tap3_seen = '0;

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] reduce(input logic signed [32:0] r);
    logic signed [32:0] s;
    s = r >>> SHIFT;
`ifdef FIR_SAT_EN
    if (s > 33'sd32767) return 16'h7FFF;
    if (s < -33'sd32768) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  function automatic logic signed [32:0] model_sum();
    logic signed [32:0] sum = '0;
    for (int k = 0; k < int'(NTAPS); k++)
      sum = sum + $signed(coef_m[k]) * x_win[k];
    return sum;
  endfunction

  // DSP model: accumulate on mac_en, result visible MAC_LAT cycles after the last MAC.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_clr_o) acc <= '0;
    else if (mac_en_o) acc <= acc + $signed(tap_o) * x_win[tapnum_o[3:0]];
    res_q <= acc;
  end
  assign result_i = ovr_en ? ovr_val : res_q;

  always @(negedge clk) begin
    if (mon_en && !rst_i) begin
      if (overrun_o) ovr_cnt++;
      if (mac_en_o) begin
        check_eq("tap_coef", 33'(tap_o), 33'(coef_m[tapnum_o[3:0]]));
        if (tapnum_o == 8'd3) tap3_seen = tap_o;
      end else begin
        check_eq("tap_idle", 33'({tapnum_o, tap_o}), 33'(0));
      end
      if (y_valid_o) begin
        yv_cnt++;
        last_y = y_o;
        if (sb.size() == 0) begin
          check_eq("spurious_yv", 33'(y_valid_o), 33'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("y", 33'(y_o), 33'(e.y));
          check_eq("y_lat", 33'(cyc), 33'(e.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_clr"}, 33'(mac_clr_o), 33'(0));
    check_eq({tag, "_en"}, 33'(mac_en_o), 33'(0));
    check_eq({tag, "_tap"}, 33'({tapnum_o, tap_o}), 33'(0));
    check_eq({tag, "_busy"}, 33'(busy_o), 33'(0));
    check_eq({tag, "_y"}, 33'({y_valid_o, y_o}), 33'(0));
    check_eq({tag, "_flags"}, 33'({overrun_o, coef_rej_o}), 33'(0));
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [15:0] d, input bit ok);
    coef_we_i = 1'b1; coef_addr_i = a; coef_data_i = d;
    tick();
    coef_we_i = 1'b0;
    check_eq("coef_rej", 33'(coef_rej_o), 33'(!ok));
    if (ok) coef_m[a] = d;
  endtask

  task automatic start();
    exp_t e;
    e.y   = ovr_en ? reduce($signed(ovr_val)) : reduce(model_sum());
    e.cyc = cyc + LAT;
    sb.push_back(e);
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    check_eq("mac_clr", 33'({mac_clr_o, busy_o}), 33'(2'b11));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("timeout", 33'(sb.size()), 33'(0));
      sb.delete();
    end
    repeat (2) tick();
  endtask

  task automatic load_ramp();
    for (int k = 0; k < int'(NTAPS); k++) write_coef(4'(k), 16'(k), 1'b1);
  endtask

  initial begin
    int yv0, ov0;
    rst_i = 1'b1; sample_valid_i = 1'b0; coef_we_i = 1'b0;
    coef_addr_i = '0; coef_data_i = '0;
    for (int k = 0; k < 16; k++) begin coef_m[k] = '0; x_win[k] = 16'(k); end
    repeat (2) tick();
    rst_i = 1'b0;
    check_zero("rst");
    mon_en = 1'b1;

    // Basic ramp: sum k*k = 285
    load_ramp();
    start();
    wait_done(40);
    check_eq("basic_y", 33'(last_y), 33'(16'h011D));

    // Random coefficients and windows
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < int'(NTAPS); k++) begin
        write_coef(4'(k), 16'($urandom_range(0, 4095)) - 16'd2048, 1'b1);
        x_win[k] = 16'($urandom_range(0, 65535));
      end
      start();
      wait_done(40);
    end

    // Output reduction at the 16-bit boundaries
    ovr_en = 1'b1;
    ovr_val = 33'd65536;
    start();
    wait_done(40);
`ifdef FIR_SAT_EN
    check_eq("sat_pos", 33'(last_y), 33'(16'h7FFF));
`else
    check_eq("wrap_pos", 33'(last_y), 33'(16'h0000));
`endif
    ovr_val = -33'sd65536;
    start();
    wait_done(40);
`ifdef FIR_SAT_EN
    check_eq("sat_neg", 33'(last_y), 33'(16'h8000));
`else
    check_eq("wrap_neg", 33'(last_y), 33'(16'h0000));
`endif
    ovr_en = 1'b0;

    // Overrun: second request at cycle 5
    for (int k = 0; k < 16; k++) x_win[k] = 16'(k);
    load_ramp();
    yv0 = yv_cnt; ov0 = ovr_cnt;
    start();
    repeat (4) tick();
    sample_valid_i = 1'b1;
    tick();
    sample_valid_i = 1'b0;
    check_eq("overrun_pulse", 33'({overrun_o, busy_o}), 33'(2'b11));
    wait_done(40);
    check_eq("overrun_yv_cnt", 33'(yv_cnt - yv0), 33'(1));
    check_eq("overrun_cnt", 33'(ovr_cnt - ov0), 33'(1));

    // Back-to-back: requests at cycles 0 and 14
    yv0 = yv_cnt; ov0 = ovr_cnt;
    start();
    repeat (13) tick();
    check_eq("b2b_out_state", 33'({y_valid_o, busy_o}), 33'(2'b10));
    start();
    wait_done(60);
    check_eq("b2b_yv_cnt", 33'(yv_cnt - yv0), 33'(2));
    check_eq("b2b_no_overrun", 33'(ovr_cnt - ov0), 33'(0));

    // Coefficient rejection while busy and out of range
    start();
    repeat (3) tick();
    write_coef(4'd3, 16'h0007, 1'b0);
    wait_done(40);
    write_coef(4'd12, 16'h0055, 1'b0);
    tap3_seen = '0;
    start();
    wait_done(40);
    check_eq("rej_tap3", 33'(tap3_seen), 33'(3));

    // Reset in the middle of RUN
    yv0 = yv_cnt;
    start();
    repeat (5) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    sb.delete();
    for (int k = 0; k < 16; k++) coef_m[k] = '0;
    check_zero("midrst");
    repeat (20) tick();
    check_eq("midrst_no_yv", 33'(yv_cnt - yv0), 33'(0));
    start();
    wait_done(40);
    check_eq("midrst_coef_zero_y", 33'(last_y), 33'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 The block SHALL have one clock, clk_i, and a synchronous, active-high reset, rst_i.
REQ-002 Parameter NTAPS, default 10, SHALL set the number of filter taps (legal range 1..16).
REQ-003 Parameter MAC_LAT, default 2, SHALL set the dsp pipeline latency in cycles from the last mac_en_o to a valid result_i.
REQ-004 Parameter SHIFT, default 0, SHALL set the arithmetic right shift applied to result_i (legal range 0..16).
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 sample_valid_i  in  1  a new signal window is ready; request for one filter output.
REQ-008 coef_we_i  in  1  coefficient write strobe.
REQ-009 coef_addr_i  in  4  coefficient index.
REQ-010 coef_data_i  in  16  coefficient value, signed.
REQ-011 result_i  in  33  accumulated dsp result, signed.
REQ-012 mac_clr_o  out  1  clears the dsp accumulator.
REQ-013 mac_en_o  out  1  dsp clock enable for one MAC.
REQ-014 tapnum_o  out  8  current tap index to the dsp.
REQ-015 tap_o  out  16  coefficient for tapnum_o, valid in the same cycle.
REQ-016 busy_o  out  1  high in CLEAR, RUN and DRAIN.
REQ-017 y_o  out  16  scaled filter output.
REQ-018 y_valid_o  out  1  one-cycle pulse qualifying y_o.
REQ-019 overrun_o  out  1  one-cycle pulse when a sample request is dropped.
REQ-020 coef_rej_o  out  1  one-cycle pulse when a coefficient write is rejected.

Function
REQ-021 The FSM SHALL have states IDLE, CLEAR, RUN, DRAIN and OUTPUT, with all outputs registered.
REQ-022 When sample_valid_i is high in IDLE or OUTPUT, the FSM SHALL enter CLEAR on the next cycle, which asserts mac_clr_o for exactly one cycle.
REQ-023 CLEAR SHALL go to RUN. RUN SHALL last NTAPS cycles with mac_en_o=1 and tapnum_o counting 0..NTAPS-1, and tap_o=coef[tapnum_o].
REQ-024 RUN SHALL go to DRAIN, which lasts MAC_LAT cycles with mac_en_o=0. DRAIN SHALL then go to OUTPUT, which lasts one cycle.
REQ-025 In OUTPUT, y_valid_o SHALL be 1 and y_o SHALL be the scaled result_i. Latency from sample_valid_i to y_valid_o SHALL be NTAPS+MAC_LAT+2 cycles (14 by default).
REQ-026 OUTPUT SHALL go to IDLE, or to CLEAR if sample_valid_i is high (back-to-back operation with no gap).
REQ-027 When sample_valid_i is high in CLEAR, RUN or DRAIN, the request SHALL be dropped and overrun_o SHALL pulse on the next cycle, without disturbing the current sequence.
REQ-028 A coefficient write in IDLE or OUTPUT with coef_addr_i<NTAPS SHALL update coef[coef_addr_i] on the next edge.
REQ-029 A coefficient write while busy_o=1, or with coef_addr_i>=NTAPS, SHALL leave the coefficients unchanged and pulse coef_rej_o on the next cycle.
REQ-030 Scaling SHALL be: s = result_i >>> SHIFT (signed arithmetic shift on 33 bits), then reduced to 16 bits per REQ-036/REQ-037.
REQ-031 Outside RUN, tapnum_o and tap_o SHALL hold 0.

Reset
REQ-032 When rst_i is high at a clock edge, the FSM SHALL enter IDLE from any state, including mid-RUN, and no y_valid_o SHALL be produced for the aborted sequence.
REQ-033 After reset, every output SHALL be 0 and every coefficient SHALL be 0.
REQ-034 Reset SHALL take priority over sample_valid_i and coef_we_i in the same cycle.

Configuration
REQ-035 Macro FIR_SAT_EN SHALL select the output reduction mode.
REQ-036 With FIR_SAT_EN defined, s SHALL saturate to the range [-32768, 32767].
REQ-037 Without FIR_SAT_EN, y_o SHALL be s[15:0] (wrap-around).

Verification
REQ-038 Basic: load coef[k]=k for k=0..9, pulse sample_valid_i at cycle 0, model returns result_i=285 -> mac_clr_o at cycle 1, mac_en_o at cycles 2-11 with tapnum_o 0..9 and tap_o 0..9, y_valid_o at cycle 14 with y_o=0x011D.
REQ-039 Saturation: result_i=65536, SHIFT=0 -> y_o=0x7FFF with FIR_SAT_EN; y_o=0x0000 without it. result_i=-65536 -> 0x8000 with FIR_SAT_EN; 0x0000 without it.
REQ-040 Overrun: second sample_valid_i at cycle 5 -> overrun_o pulse at cycle 6, exactly one y_valid_o, at cycle 14.
REQ-041 Back-to-back: sample_valid_i at cycles 0 and 14 -> mac_clr_o at cycles 1 and 15, y_valid_o at cycles 14 and 28, overrun_o never asserted.
REQ-042 Reset mid-RUN: rst_i at cycle 6 -> all outputs 0 from cycle 7, FIR in IDLE, no y_valid_o, coefficients read back as 0.
REQ-043 Coefficient rejection: coef_we_i with addr 3, data 0x7 at cycle 4 (busy), or with addr 12 while idle -> coef_rej_o pulses and the next run shows tap_o=3 at tapnum_o=3.
